// File: rtl/pixel_window_scaler.sv
// pixel_window_scaler: crops a pixel stream to a per-frame window and decimates it by 2^xs (skip/average) x 2^ys (skip).
module pixel_window_scaler #(
    parameter int CHANNELS    = 3,
    parameter int DATA_WIDTH  = 10,
    parameter int COORD_WIDTH = 11,
    parameter int MAX_SHIFT   = 2,
    parameter int SW          = $clog2(MAX_SHIFT + 1)
) (
    input  logic                           clock_in,
    input  logic                           reset_in,
    input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
    input  logic                           line_valid_in,
    input  logic                           frame_valid_in,
    input  logic [COORD_WIDTH-1:0]         x_start_in,
    input  logic [COORD_WIDTH-1:0]         x_end_in,
    input  logic [COORD_WIDTH-1:0]         y_start_in,
    input  logic [COORD_WIDTH-1:0]         y_end_in,
    input  logic [SW-1:0]                  x_shift_in,
    input  logic [SW-1:0]                  y_shift_in,
    input  logic                           average_mode_in,
    output logic [CHANNELS*DATA_WIDTH-1:0] data_out,
    output logic                           line_valid_out,
    output logic                           frame_valid_out,
    output logic [COORD_WIDTH-1:0]         x_size_out,
    output logic [COORD_WIDTH-1:0]         y_size_out
);
    localparam int PW = CHANNELS * DATA_WIDTH;
    localparam int AW = DATA_WIDTH + MAX_SHIFT;
    localparam logic [SW-1:0] MAXS = SW'(MAX_SHIFT);

    logic                   fv_q, lv_q, armed_q, avg_q, lvo_q, fvo_q;
    logic [COORD_WIDTH-1:0] x_q, x_d, y_q, y_d, x0_q, x1_q, y0_q, y1_q, xsz_q, xsz_d, ysz_q, ysz_d;
    logic [SW-1:0]          xsh_q, ysh_q, xsh_in, ysh_in, xsh, ysh;
    logic [PW-1:0]          data_q, avg_pix;
    logic [COORD_WIDTH-1:0] x0, x1, y0, y1, y_cur, rx, ry, mx, my;
    logic                   fv_rise, avg, in_win, active, grp_start, emit;

    assign fv_rise = frame_valid_in & ~fv_q;
    assign xsh_in  = (x_shift_in > MAXS) ? MAXS : x_shift_in;
    assign ysh_in  = (y_shift_in > MAXS) ? MAXS : y_shift_in;

    // The shadow is bypassed on the load cycle so pixel 0 of line 0 already sees the new window.
    assign x0  = fv_rise ? x_start_in      : x0_q;
    assign x1  = fv_rise ? x_end_in        : x1_q;
    assign y0  = fv_rise ? y_start_in      : y0_q;
    assign y1  = fv_rise ? y_end_in        : y1_q;
    assign xsh = fv_rise ? xsh_in          : xsh_q;
    assign ysh = fv_rise ? ysh_in          : ysh_q;
    assign avg = fv_rise ? average_mode_in : avg_q;

    assign y_cur = fv_rise ? '0 : y_q;
    assign rx    = x_q - x0;
    assign ry    = y_cur - y0;
    assign mx    = ~({COORD_WIDTH{1'b1}} << xsh);
    assign my    = ~({COORD_WIDTH{1'b1}} << ysh);

    assign in_win    = (x_q >= x0) && (x_q < x1) && (y_cur >= y0) && (y_cur < y1);
    assign active    = frame_valid_in & line_valid_in & in_win & ((ry & my) == my) & (armed_q | fv_rise);
    assign grp_start = (rx & mx) == '0;
    assign emit      = active & ((rx & mx) == mx);

    always_comb begin
        x_d   = line_valid_in ? ((&x_q) ? x_q : x_q + 1'b1) : '0;
        y_d   = fv_rise ? '0 : (lv_q & ~line_valid_in & ~(&y_q)) ? y_q + 1'b1 : y_q;
        xsz_d = (x1 > x0) ? (x1 - x0) >> xsh : '0;
        ysz_d = (y1 > y0) ? (y1 - y0) >> ysh : '0;
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [AW-1:0]         acc_q, sum;
        logic [DATA_WIDTH-1:0] pix;
        assign pix = data_in[c*DATA_WIDTH +: DATA_WIDTH];
        assign sum = (grp_start ? '0 : acc_q) + AW'(pix);
        assign avg_pix[c*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(sum >> xsh);
        always_ff @(posedge clock_in) begin
            if (reset_in)
                acc_q <= '0;
            else if (active)
                acc_q <= sum;
        end
    end

    // fv_q resets high so a frame already in progress at reset is not taken as a new frame.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            fv_q    <= 1'b1;
            lv_q    <= 1'b0;
            armed_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            x0_q    <= '0;
            x1_q    <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            xsh_q   <= '0;
            ysh_q   <= '0;
            avg_q   <= 1'b0;
            data_q  <= '0;
            lvo_q   <= 1'b0;
            fvo_q   <= 1'b0;
            xsz_q   <= '0;
            ysz_q   <= '0;
        end else begin
            fv_q    <= frame_valid_in;
            lv_q    <= line_valid_in;
            armed_q <= armed_q | fv_rise;
            x_q     <= x_d;
            y_q     <= y_d;
            if (fv_rise) begin
                x0_q  <= x_start_in;
                x1_q  <= x_end_in;
                y0_q  <= y_start_in;
                y1_q  <= y_end_in;
                xsh_q <= xsh_in;
                ysh_q <= ysh_in;
                avg_q <= average_mode_in;
            end
            if (emit)
                data_q <= avg ? avg_pix : data_in;
            lvo_q   <= emit;
            fvo_q   <= frame_valid_in & (armed_q | fv_rise);
            xsz_q   <= xsz_d;
            ysz_q   <= ysz_d;
        end
    end

    assign data_out        = data_q;
    assign line_valid_out  = lvo_q;
    assign frame_valid_out = fvo_q;
    assign x_size_out      = xsz_q;
    assign y_size_out      = ysz_q;
endmodule

// File: tb/tb_pixel_window_scaler.sv
// tb_pixel_window_scaler: directed frames with a scoreboard queue of hand-derived output pixels.
module tb_pixel_window_scaler;
    logic        clock_in = 1'b0;
    logic        reset_in;
    logic [29:0] data_in;
    logic        line_valid_in, frame_valid_in;
    logic [10:0] x_start_in, x_end_in, y_start_in, y_end_in;
    logic [1:0]  x_shift_in, y_shift_in;
    logic        average_mode_in;
    logic [29:0] data_out;
    logic        line_valid_out, frame_valid_out;
    logic [10:0] x_size_out, y_size_out;

    int vectors = 0;
    int miscompares = 0;
    logic [29:0] exp_q[$];

    pixel_window_scaler dut (
        .clock_in(clock_in), .reset_in(reset_in), .data_in(data_in),
        .line_valid_in(line_valid_in), .frame_valid_in(frame_valid_in),
        .x_start_in(x_start_in), .x_end_in(x_end_in), .y_start_in(y_start_in), .y_end_in(y_end_in),
        .x_shift_in(x_shift_in), .y_shift_in(y_shift_in), .average_mode_in(average_mode_in),
        .data_out(data_out), .line_valid_out(line_valid_out), .frame_valid_out(frame_valid_out),
        .x_size_out(x_size_out), .y_size_out(y_size_out)
    );

    initial forever #5 clock_in = ~clock_in;

    function automatic logic [29:0] pix(input int x);
        return {10'(1023 - x), 10'(x + 32), 10'(x)};
    endfunction

    // Floor of the per-channel mean of n consecutive pixels starting at column first.
    function automatic logic [29:0] avg_exp(input int first, input int n);
        int s0 = 0, s1 = 0, s2 = 0;
        logic [29:0] p;
        for (int i = 0; i < n; i++) begin
            p = pix(first + i);
            s0 += int'(p[9:0]);
            s1 += int'(p[19:10]);
            s2 += int'(p[29:20]);
        end
        return {10'(s2 / n), 10'(s1 / n), 10'(s0 / n)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock_in);
        #1;
    endtask

    task automatic cfg(input int xs, input int xe, input int ys, input int ye, input int xsh, input int ysh, input logic av);
        x_start_in = 11'(xs);
        x_end_in = 11'(xe);
        y_start_in = 11'(ys);
        y_end_in = 11'(ye);
        x_shift_in = 2'(xsh);
        y_shift_in = 2'(ysh);
        average_mode_in = av;
    endtask

    task automatic run_frame(input int w, input int h, input int chg_line, input int chg_xs, input int rst_line);
        frame_valid_in = 1'b1;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                line_valid_in = 1'b1;
                data_in = pix(x);
                if (y == chg_line && x == 0) x_start_in = 11'(chg_xs);
                reset_in = (y == rst_line && x == 3);
                tick;
                if (y == 0 && x == 0) chk("fvo_rise", 32'(frame_valid_out), 32'd1);
                if (reset_in) begin
                    chk("rst_data", 32'(data_out), 32'd0);
                    chk("rst_lvo", 32'(line_valid_out), 32'd0);
                    chk("rst_fvo", 32'(frame_valid_out), 32'd0);
                    chk("rst_xsize", 32'(x_size_out), 32'd0);
                    chk("rst_ysize", 32'(y_size_out), 32'd0);
                end
                if (y == rst_line && x == w - 1) chk("post_rst_fvo", 32'(frame_valid_out), 32'd0);
            end
            line_valid_in = 1'b0;
            reset_in = 1'b0;
            repeat (3) tick;
        end
        chk("fvo_before_fall", 32'(frame_valid_out), (rst_line < 0) ? 32'd1 : 32'd0);
        frame_valid_in = 1'b0;
        tick;
        chk("fvo_after_fall", 32'(frame_valid_out), 32'd0);
        repeat (3) tick;
        chk("missing_pixels", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic push_skip(input int x0, input int x1, input int y0, input int y1);
        for (int y = y0; y < y1; y++)
            for (int x = x0; x < x1; x++)
                exp_q.push_back(pix(x));
    endtask

    initial begin : monitor
        logic [29:0] e;
        forever begin
            @(negedge clock_in);
            if (line_valid_out) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL extra_pixel actual=%0h required=none", data_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("pixel", 32'(data_out), 32'(e));
                end
            end
        end
    end

    initial begin
        reset_in = 1'b1;
        data_in = '0;
        line_valid_in = 1'b0;
        frame_valid_in = 1'b0;
        cfg(0, 0, 0, 0, 0, 0, 1'b0);
        repeat (3) tick;
        chk("init_data", 32'(data_out), 32'd0);
        chk("init_lvo", 32'(line_valid_out), 32'd0);
        chk("init_fvo", 32'(frame_valid_out), 32'd0);
        chk("init_xsize", 32'(x_size_out), 32'd0);
        chk("init_ysize", 32'(y_size_out), 32'd0);
        reset_in = 1'b0;
        repeat (2) tick;

        cfg(2, 10, 1, 5, 0, 0, 1'b0);
        push_skip(2, 10, 1, 5);
        run_frame(16, 8, -1, 0, -1);
        chk("s1_xsize", 32'(x_size_out), 32'd8);
        chk("s1_ysize", 32'(y_size_out), 32'd4);

        cfg(2, 10, 1, 5, 1, 0, 1'b1);
        for (int y = 0; y < 4; y++)
            for (int k = 1; k <= 4; k++)
                exp_q.push_back(avg_exp(2 * k, 2));
        run_frame(16, 8, -1, 0, -1);
        chk("s2_xsize", 32'(x_size_out), 32'd4);
        chk("s2_ysize", 32'(y_size_out), 32'd4);

        cfg(0, 7, 0, 8, 2, 1, 1'b0);
        repeat (4) exp_q.push_back(pix(3));
        run_frame(16, 8, -1, 0, -1);
        chk("s3_xsize", 32'(x_size_out), 32'd1);
        chk("s3_ysize", 32'(y_size_out), 32'd4);

        cfg(0, 8, 0, 2, 3, 0, 1'b1);
        repeat (2) begin
            exp_q.push_back(avg_exp(0, 4));
            exp_q.push_back(avg_exp(4, 4));
        end
        run_frame(16, 4, -1, 0, -1);
        chk("clamp_xsize", 32'(x_size_out), 32'd2);
        chk("clamp_ysize", 32'(y_size_out), 32'd2);

        cfg(5, 5, 1, 5, 0, 0, 1'b0);
        run_frame(16, 8, -1, 0, -1);
        chk("empty_xsize", 32'(x_size_out), 32'd0);

        cfg(2, 10, 1, 5, 0, 0, 1'b0);
        push_skip(2, 10, 1, 5);
        run_frame(16, 8, 2, 4, -1);
        chk("shadow_xsize", 32'(x_size_out), 32'd8);
        push_skip(4, 10, 1, 5);
        run_frame(16, 8, -1, 0, -1);
        chk("next_xsize", 32'(x_size_out), 32'd6);
        chk("next_ysize", 32'(y_size_out), 32'd4);

        cfg(2, 10, 1, 5, 0, 0, 1'b0);
        run_frame(16, 8, -1, 0, 0);
        chk("rstframe_xsize", 32'(x_size_out), 32'd0);
        push_skip(2, 10, 1, 5);
        run_frame(16, 8, -1, 0, -1);
        chk("after_rst_xsize", 32'(x_size_out), 32'd8);
        chk("after_rst_ysize", 32'(y_size_out), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pixel_window_scaler.md
# pixel_window_scaler

Parametrised pixel-stream crop-and-downscale stage for the camera pipeline. Takes N-channel pixels qualified by frame/line valid and applies a runtime rectangular window. Decimates by a power of two in X (skip or average) and Y (skip). Emits a reduced stream plus its output dimensions for the JPEG encoder. Supersedes the fixed 3-channel crop between debayer and encoder; window configuration is shadowed per frame.

## Interface
Parameters:
- CHANNELS, 3, number of colour channels packed in the data bus
- DATA_WIDTH, 10, bits per channel
- COORD_WIDTH, 11, bits per coordinate/counter
- MAX_SHIFT, 2, largest decimation shift (factor 2^MAX_SHIFT); SW = $clog2(MAX_SHIFT+1)

Ports:
- clock_in  input  1  pixel clock
- reset_in  input  1  synchronous, active-high reset
- data_in  input  CHANNELS*DATA_WIDTH  packed pixel; channel 0 in LSBs
- line_valid_in  input  1  per-pixel qualifier, high across a line
- frame_valid_in  input  1  high across a frame
- x_start_in, x_end_in  input  COORD_WIDTH  window columns [start, end)
- y_start_in, y_end_in  input  COORD_WIDTH  window lines [start, end)
- x_shift_in, y_shift_in  input  SW  decimation shift; values > MAX_SHIFT clamp to MAX_SHIFT
- average_mode_in  input  1  1 = horizontal box average, 0 = horizontal skip
- data_out  output  CHANNELS*DATA_WIDTH  output pixel
- line_valid_out  output  1  per-pixel strobe, one cycle per emitted pixel (gapped)
- frame_valid_out  output  1  frame_valid_in delayed 1 cycle, gated by armed state
- x_size_out, y_size_out  output  COORD_WIDTH  output dimensions of current frame

## Operation
- Config shadow: all *_in config latched on the rising edge of frame_valid_in; changes mid-frame have no effect until the next frame.
- Armed flag: cleared by reset; set on the first frame_valid_in rising edge. Before that, no outputs are asserted (prevents partial frame after mid-frame reset).
- x counter: counts line_valid_in-high cycles within a line; cleared when line_valid_in falls. y counter: incremented on each line_valid_in falling edge; cleared on frame_valid_in rising. Both saturate at 2^COORD_WIDTH-1.
- In-window: x_start<=x<x_end and y_start<=y<y_end. If end<=start on either axis, zero pixels are emitted for the frame; frame_valid_out still toggles.
- Relative coords rx=x-x_start, ry=y-y_start; group mask mx=2^xs-1, my=2^ys-1.
- Line kept when (ry & my)==my. Pixel emitted when in-window, line kept, and (rx & mx)==mx.
- Skip mode: emitted value = the current (last-of-group) pixel.
- Average mode: per-channel accumulator, DATA_WIDTH+MAX_SHIFT bits, cleared at group start ((rx & mx)==0); emitted value = (acc + pixel) >> xs, truncated (floor). No rounding.
- Trailing partial X group (width not a multiple of 2^xs) is discarded; trailing partial Y group emits nothing.
- x_size_out=(x_end-x_start)>>xs, y_size_out=(y_end-y_start)>>ys, from shadow; 0 if end<=start. Updated the cycle after shadow load.

## Timing
- Reset values: data_out=0, line_valid_out=0, frame_valid_out=0, x_size_out=0, y_size_out=0, accumulators/counters 0, armed=0.
- Latency: 1 cycle from the input pixel that completes a group to line_valid_out/data_out. data_out holds last emitted value between strobes.
- frame_valid_out = 1-cycle delayed frame_valid_in, so it falls after the last line_valid_out.
- Shadow load and pixel 0 of line 0 in the same cycle: new config applies to that pixel.
- No backpressure; one input pixel per cycle max, output rate <= input rate.
- Reset mid-frame: all outputs 0 next cycle; nothing emitted until next frame_valid_in rise.

## Test plan
- 16x8 frame, data=x, window x 2..10, y 1..5, shifts 0, skip -> 8 pixels/line x 4 lines, first output 2, sizes 8/4.
- Same window, xs=1, average, data=x -> per line outputs 2,4,6,8 (floor of 2.5,4.5,...), 4 lines, x_size_out=4.
- xs=2, ys=1, skip, window x 0..7, y 0..8 -> one pixel/line value 3, lines y=1,3,5,7 kept, sizes 1/4.
- x_end=x_start=5 -> zero line_valid_out pulses; frame_valid_out mirrors input +1 cycle; sizes 0.
- Change x_start 2->4 mid-frame -> current frame still starts at x=2; next frame first output 4.
- Assert reset_in for 1 cycle mid-line -> outputs 0 next cycle; no pixels until next frame rise; next frame matches scenario 1 exactly.
